// File: rtl/math_pkg.sv
// Shared definitions for the math unit: divider state encoding,
// widths and the sign/magnitude helpers also used by the multiplier.
package math_pkg;

    localparam int DIV_W  = 24;
    localparam int DIV_CW = $clog2(DIV_W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    // One extra bit so the most negative operand has a representable magnitude.
    function automatic logic [DIV_W:0] abs_ext(input logic [DIV_W-1:0] x);
        logic [DIV_W:0] e;
        e = {x[DIV_W-1], x};
        return x[DIV_W-1] ? -e : e;
    endfunction

    function automatic logic [DIV_W-1:0] neg_if(
        input logic [DIV_W-1:0] x,
        input logic             en
    );
        return en ? -x : x;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Radix-2 restoring signed divider, one quotient bit per clock,
// with a start/done handshake and div-by-zero / overflow flags.
module seq_divider
    import math_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam logic [W:0] MIN_MAG = {2'b01, {(W-1){1'b0}}};
    localparam logic [W:0] ONE     = (W+1)'(1);

    div_state_t state, state_n;

    logic [DIV_CW-1:0] cnt;
    logic [W-1:0]      acc;
    logic [W-1:0]      q_sh;
    logic [W:0]        dvs_m;
    logic [W-1:0]      dvd_raw;
    logic              neg_q;
    logic              neg_r;
    logic              ovf_p;
    logic              dz_p;

    logic [W:0] dvd_abs;
    logic [W:0] dvs_abs;
    logic [W:0] sh;
    logic [W:0] diff;

    assign dvd_abs = abs_ext(dividend);
    assign dvs_abs = abs_ext(divisor);
    assign sh      = {acc, q_sh[W-1]};
    assign diff    = sh - dvs_m;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = (state != IDLE);
        done    = (state == DONE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = (divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_n = FIX;
                end
            end
            FIX:     state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt         <= '0;
            acc         <= '0;
            q_sh        <= '0;
            dvs_m       <= '0;
            dvd_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            ovf_p       <= 1'b0;
            dz_p        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= DIV_CW'(W-1);
                        acc     <= '0;
                        q_sh    <= dvd_abs[W-1:0];
                        dvs_m   <= dvs_abs;
                        dvd_raw <= dividend;
                        neg_q   <= dividend[W-1] ^ divisor[W-1];
                        neg_r   <= dividend[W-1];
                        dz_p    <= (divisor == '0);
                        // Only -2^(W-1) has this magnitude; |b|==1 with sign set is -1.
                        ovf_p   <= (dvd_abs == MIN_MAG) && (dvs_abs == ONE)
                                   && divisor[W-1];
                    end
                end
                CALC: begin
                    if (diff[W]) begin
                        acc <= {acc[W-2:0], q_sh[W-1]};
                    end else begin
                        acc <= diff[W-1:0];
                    end
                    q_sh <= {q_sh[W-2:0], ~diff[W]};
                    cnt  <= cnt - DIV_CW'(1);
                end
                FIX: begin
                    if (dz_p) begin
                        quotient    <= '1;
                        remainder   <= dvd_raw;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        quotient    <= neg_if(q_sh, neg_q);
                        remainder   <= neg_if(acc, neg_r);
                        div_by_zero <= 1'b0;
                        overflow    <= ovf_p;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
